// File: rtl/lsu_pkg.sv
// Shared definitions for the RV32I load/store unit: access encodings, FSM states
// and the request legality / store lane helpers.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } lsu_state_t;

    function automatic logic is_aligned(input logic [2:0] funct3, input logic [1:0] addr);
        logic ok;
        case (funct3)
            F3_W:       ok = (addr == 2'b00);
            F3_H, F3_HU: ok = (addr[0] == 1'b0);
            default:    ok = 1'b1;
        endcase
        return ok;
    endfunction

    // Exactly one of load/store must be requested, with a size code valid for that direction.
    function automatic logic is_legal(input logic rd, input logic wr, input logic [2:0] funct3);
        logic ok;
        ok = 1'b0;
        if (rd && !wr) begin
            case (funct3)
                F3_B, F3_H, F3_W, F3_BU, F3_HU: ok = 1'b1;
                default:                        ok = 1'b0;
            endcase
        end else if (wr && !rd) begin
            case (funct3)
                F3_B, F3_H, F3_W: ok = 1'b1;
                default:          ok = 1'b0;
            endcase
        end else begin
            ok = 1'b0;
        end
        return ok;
    endfunction

    function automatic logic [3:0] store_be(input logic [2:0] funct3, input logic [1:0] offset);
        logic [3:0] be;
        case (funct3)
            F3_B:    be = 4'b0001 << offset;
            F3_H:    be = 4'b0011 << offset;
            F3_W:    be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] store_wdata(input logic [2:0] funct3, input logic [31:0] wd);
        logic [31:0] data;
        case (funct3)
            F3_B:    data = {4{wd[7:0]}};
            F3_H:    data = {2{wd[15:0]}};
            F3_W:    data = wd;
            default: data = 32'h0000_0000;
        endcase
        return data;
    endfunction

endpackage

// File: rtl/load_store_unit_load_extend.sv
// Load data alignment: moves the addressed byte/halfword down to bit 0 and
// sign- or zero-extends it according to the load type.
module load_extend
    import lsu_pkg::*;
(
    input  logic [31:0] MemRdata,
    input  logic [1:0]  offset,
    input  logic [2:0]  Funct3,
    output logic [31:0] ext_data
);

    logic [31:0] shifted_s;

    assign shifted_s = MemRdata >> {offset, 3'b000};

    // Select width and extension mode of the loaded value.
    always_comb begin
        ext_data = 32'h0000_0000;
        case (Funct3)
            F3_B:    ext_data = {{24{shifted_s[7]}}, shifted_s[7:0]};
            F3_H:    ext_data = {{16{shifted_s[15]}}, shifted_s[15:0]};
            F3_W:    ext_data = shifted_s;
            F3_BU:   ext_data = {24'h00_0000, shifted_s[7:0]};
            F3_HU:   ext_data = {16'h0000, shifted_s[15:0]};
            default: ext_data = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Memory-stage load/store unit: runs one handshaked data-memory access per
// legal request, stalls upstream meanwhile and reports illegal accesses and timeouts.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int MAX_WAIT = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [2:0]  Funct3,
    input  logic [31:0] ALUResult,
    input  logic [31:0] WriteData,
    output logic [31:0] RD,
    output logic        LoadValid,
    output logic        Stall,
    output logic        AccessErr,
    output logic        TimeoutErr,
    output logic        MemReq,
    output logic        MemWe,
    output logic [31:0] MemAddr,
    output logic [3:0]  MemBe,
    output logic [31:0] MemWdata,
    input  logic [31:0] MemRdata,
    input  logic        MemAck
);

    localparam int CW = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);

    lsu_state_t  state_r;
    logic [CW-1:0] cnt_r;
    logic [31:0] addr_r;
    logic [2:0]  f3_r;
    logic        we_r;
    logic [3:0]  be_r;
    logic [31:0] wdata_r;
    logic [31:0] rd_r;
    logic        load_valid_r;
    logic        access_err_r;
    logic        timeout_err_r;

    logic        req_s;
    logic        legal_s;
    logic        in_access_s;
    logic [31:0] ext_s;

    assign req_s       = MemRead | MemWrite;
    assign legal_s     = is_legal(MemRead, MemWrite, Funct3) & is_aligned(Funct3, ALUResult[1:0]);
    assign in_access_s = (state_r == ACCESS);

    load_extend u_load_extend (
        .MemRdata (MemRdata),
        .offset   (addr_r[1:0]),
        .Funct3   (f3_r),
        .ext_data (ext_s)
    );

    // Access sequencing, request latching, result capture and one-cycle status pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= IDLE;
            cnt_r         <= {CW{1'b0}};
            addr_r        <= 32'h0000_0000;
            f3_r          <= 3'b000;
            we_r          <= 1'b0;
            be_r          <= 4'b0000;
            wdata_r       <= 32'h0000_0000;
            rd_r          <= 32'h0000_0000;
            load_valid_r  <= 1'b0;
            access_err_r  <= 1'b0;
            timeout_err_r <= 1'b0;
        end else begin
            load_valid_r  <= 1'b0;
            access_err_r  <= 1'b0;
            timeout_err_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (req_s && legal_s) begin
                        addr_r  <= ALUResult;
                        f3_r    <= Funct3;
                        we_r    <= MemWrite;
                        be_r    <= MemWrite ? store_be(Funct3, ALUResult[1:0]) : 4'b0000;
                        wdata_r <= MemWrite ? store_wdata(Funct3, WriteData) : 32'h0000_0000;
                        cnt_r   <= {CW{1'b0}};
                        state_r <= ACCESS;
                    end else if (req_s) begin
                        access_err_r <= 1'b1;
                    end
                end
                ACCESS: begin
                    // An acknowledge arriving on the last allowed cycle still completes normally.
                    if (MemAck) begin
                        if (!we_r) begin
                            rd_r         <= ext_s;
                            load_valid_r <= 1'b1;
                        end
                        state_r <= DONE;
                    end else if (cnt_r == CW'(MAX_WAIT)) begin
                        timeout_err_r <= 1'b1;
                        if (!we_r) begin
                            rd_r         <= 32'h0000_0000;
                            load_valid_r <= 1'b1;
                        end
                        state_r <= DONE;
                    end else begin
                        cnt_r <= cnt_r + CW'(1);
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    // The idle-side stall term depends on live inputs, so it is gated to stay low in reset.
    assign Stall      = rst_n & (((state_r == IDLE) & req_s & legal_s) | in_access_s);
    assign MemReq     = in_access_s;
    assign MemWe      = in_access_s & we_r;
    assign MemAddr    = {addr_r[31:2], 2'b00};
    assign MemBe      = be_r;
    assign MemWdata   = wdata_r;
    assign RD         = rd_r;
    assign LoadValid  = load_valid_r;
    assign AccessErr  = access_err_r;
    assign TimeoutErr = timeout_err_r;

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized self-checking bench for load_store_unit with a word-array memory
// model and arithmetic load/store reference.
module tb_load_store_unit;

    localparam int MAX_WAIT = 15;

    logic        clk;
    logic        rst_n;
    logic        MemRead;
    logic        MemWrite;
    logic [2:0]  Funct3;
    logic [31:0] ALUResult;
    logic [31:0] WriteData;
    logic [31:0] RD;
    logic        LoadValid;
    logic        Stall;
    logic        AccessErr;
    logic        TimeoutErr;
    logic        MemReq;
    logic        MemWe;
    logic [31:0] MemAddr;
    logic [3:0]  MemBe;
    logic [31:0] MemWdata;
    logic [31:0] MemRdata;
    logic        MemAck;

    int          checks;
    int          errors;
    logic [31:0] mem [64];
    logic [31:0] exp_rd;
    int          last_stall_cycles;
    int          last_req_cycles;

    load_store_unit #(.MAX_WAIT(MAX_WAIT)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .Funct3     (Funct3),
        .ALUResult  (ALUResult),
        .WriteData  (WriteData),
        .RD         (RD),
        .LoadValid  (LoadValid),
        .Stall      (Stall),
        .AccessErr  (AccessErr),
        .TimeoutErr (TimeoutErr),
        .MemReq     (MemReq),
        .MemWe      (MemWe),
        .MemAddr    (MemAddr),
        .MemBe      (MemBe),
        .MemWdata   (MemWdata),
        .MemRdata   (MemRdata),
        .MemAck     (MemAck)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic bit legal_req(input bit rd, input bit wr, input logic [2:0] f3,
                                     input logic [31:0] a);
        int size;
        if (rd == wr) return 1'b0;
        if (rd && !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 1'b0;
        if (wr && !(f3 inside {3'd0, 3'd1, 3'd2})) return 1'b0;
        size = 1 << f3[1:0];
        return (int'(a[1:0]) % size) == 0;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] word,
                                               input int off);
        logic [31:0] v;
        v = word >> (8 * off);
        case (f3)
            3'd0: begin v = v & 32'hFF;   if (v >= 32'd128)   v = v - 32'd256; end
            3'd1: begin v = v & 32'hFFFF; if (v >= 32'd32768) v = v - 32'd65536; end
            3'd4: v = v & 32'hFF;
            3'd5: v = v & 32'hFFFF;
            default: v = word;
        endcase
        return v;
    endfunction

    // One complete request from IDLE back to IDLE; ack_at < 0 means the memory never answers.
    task automatic run_access(input bit rd, input bit wr, input logic [2:0] f3,
                              input logic [31:0] a, input logic [31:0] wdat, input int ack_at);
        bit          legal;
        bit          acked;
        int          idx;
        int          off;
        int          k;
        logic [3:0]  exp_be;
        logic [31:0] exp_wd;
        legal = legal_req(rd, wr, f3, a);
        idx = int'(a[7:2]);
        off = int'(a[1:0]);
        MemRead = rd; MemWrite = wr; Funct3 = f3; ALUResult = a; WriteData = wdat; MemAck = 1'b0;
        #1;
        check_eq("stall_idle", Stall, legal);
        check_eq("memreq_idle", MemReq, 1'b0);
        last_stall_cycles = Stall ? 1 : 0;
        last_req_cycles = 0;
        @(posedge clk); #1;
        if (!legal) begin
            check_eq("access_err", AccessErr, (rd || wr));
            check_eq("memreq_err", MemReq, 1'b0);
            MemRead = 1'b0; MemWrite = 1'b0;
            #1;
            check_eq("stall_err", Stall, 1'b0);
            @(posedge clk); #1;
            check_eq("access_err_pulse", AccessErr, 1'b0);
            check_eq("memreq_after_err", MemReq, 1'b0);
            check_eq("rd_hold_err", RD, exp_rd);
            return;
        end
        check_eq("no_access_err", AccessErr, 1'b0);
        exp_be = 4'b0000;
        exp_wd = 32'h0;
        if (wr) begin
            case (f3)
                3'd0: begin exp_be = 4'(1 << off); exp_wd = (wdat & 32'hFF) * 32'h0101_0101; end
                3'd1: begin exp_be = 4'(3 << off); exp_wd = (wdat & 32'hFFFF) * 32'h0001_0001; end
                default: begin exp_be = 4'hF; exp_wd = wdat; end
            endcase
        end
        k = 0;
        acked = 1'b0;
        while (1) begin
            check_eq("memreq_access", MemReq, 1'b1);
            check_eq("stall_access", Stall, 1'b1);
            check_eq("memaddr", MemAddr, a & 32'hFFFF_FFFC);
            check_eq("memwe", MemWe, wr);
            check_eq("membe", MemBe, exp_be);
            if (wr) check_eq("memwdata", MemWdata, exp_wd);
            if (MemReq) last_req_cycles++;
            if (Stall) last_stall_cycles++;
            // Upstream request changes must be ignored while the access is in flight.
            MemRead = 1'($urandom); MemWrite = 1'($urandom); Funct3 = 3'($urandom);
            ALUResult = $urandom; WriteData = $urandom;
            if (k == ack_at) begin MemAck = 1'b1; MemRdata = mem[idx]; end
            else begin MemAck = 1'b0; MemRdata = $urandom; end
            @(posedge clk); #1;
            if (k == ack_at) begin acked = 1'b1; break; end
            if (k >= MAX_WAIT) break;
            k++;
        end
        MemAck = 1'($urandom); MemRdata = $urandom;
        MemRead = 1'b0; MemWrite = 1'b0;
        if (acked && wr) begin
            for (int i = 0; i < 4; i++) if (exp_be[i]) mem[idx][8*i +: 8] = exp_wd[8*i +: 8];
        end else if (acked) begin
            exp_rd = model_load(f3, mem[idx], off);
        end else if (rd) begin
            exp_rd = 32'h0;
        end
        #1;
        check_eq("loadvalid_done", LoadValid, rd);
        check_eq("timeout_done", TimeoutErr, !acked);
        check_eq("rd_done", RD, exp_rd);
        check_eq("memreq_done", MemReq, 1'b0);
        check_eq("stall_done", Stall, 1'b0);
        check_eq("accerr_done", AccessErr, 1'b0);
        @(posedge clk); #1;
        MemAck = 1'b0;
        check_eq("loadvalid_pulse", LoadValid, 1'b0);
        check_eq("timeout_pulse", TimeoutErr, 1'b0);
        check_eq("rd_hold", RD, exp_rd);
    endtask

    // Bounded run time: a hang ends the run with a reported failure.
    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    // Directed scenarios followed by randomized traffic.
    initial begin
        logic [31:0] a;
        logic [2:0]  f3;
        int          kind;
        int          ack_at;
        checks = 0; errors = 0; exp_rd = 32'h0;
        for (int i = 0; i < 64; i++) mem[i] = $urandom;
        rst_n = 1'b0;
        MemRead = 1'b1; MemWrite = 1'b0; Funct3 = 3'd2; ALUResult = 32'h100;
        WriteData = 32'hFFFF_FFFF; MemAck = 1'b1; MemRdata = 32'hFFFF_FFFF;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_stall", Stall, 1'b0);
        check_eq("rst_memreq", MemReq, 1'b0);
        check_eq("rst_rd", RD, 32'h0);
        check_eq("rst_loadvalid", LoadValid, 1'b0);
        check_eq("rst_accerr", AccessErr, 1'b0);
        check_eq("rst_timeout", TimeoutErr, 1'b0);
        check_eq("rst_memwe", MemWe, 1'b0);
        check_eq("rst_memaddr", MemAddr, 32'h0);
        check_eq("rst_membe", MemBe, 4'h0);
        check_eq("rst_memwdata", MemWdata, 32'h0);
        MemRead = 1'b0; MemAck = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        mem[0] = 32'hDEAD_BEEF;
        run_access(1'b1, 1'b0, 3'd2, 32'h100, 32'h0, 0);
        check_eq("lw_rd", RD, 32'hDEAD_BEEF);
        check_eq("lw_stall_cycles", 32'(last_stall_cycles), 32'd2);
        mem[0] = 32'h80FF_0000;
        run_access(1'b1, 1'b0, 3'd0, 32'h103, 32'h0, 1);
        check_eq("lb_rd", RD, 32'hFFFF_FF80);
        run_access(1'b1, 1'b0, 3'd4, 32'h103, 32'h0, 2);
        check_eq("lbu_rd", RD, 32'h0000_0080);
        run_access(1'b1, 1'b0, 3'd5, 32'h102, 32'h0, 0);
        check_eq("lhu_rd", RD, 32'h0000_80FF);
        run_access(1'b0, 1'b1, 3'd0, 32'h201, 32'h1234_5678, 0);
        check_eq("sb_mem", mem[0], 32'h80FF_7800 | (mem[0] & 32'h0000_00FF));
        run_access(1'b1, 1'b0, 3'd2, 32'h102, 32'h0, 0);
        run_access(1'b1, 1'b0, 3'd3, 32'h100, 32'h0, 0);
        run_access(1'b1, 1'b1, 3'd2, 32'h100, 32'h0, 0);
        run_access(1'b0, 1'b1, 3'd4, 32'h100, 32'h0, 0);
        run_access(1'b1, 1'b0, 3'd2, 32'h10, 32'h0, -1);
        check_eq("timeout_req_cycles", 32'(last_req_cycles), 32'(MAX_WAIT + 1));
        check_eq("timeout_rd", RD, 32'h0);
        run_access(1'b1, 1'b0, 3'd2, 32'h44, 32'h0, MAX_WAIT);

        // Reset while the memory access is outstanding.
        MemRead = 1'b1; MemWrite = 1'b0; Funct3 = 3'd2; ALUResult = 32'h20;
        @(posedge clk); #1;
        check_eq("midrst_memreq_before", MemReq, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("midrst_memreq", MemReq, 1'b0);
        check_eq("midrst_stall", Stall, 1'b0);
        @(posedge clk); #1;
        check_eq("midrst_loadvalid", LoadValid, 1'b0);
        check_eq("midrst_rd", RD, 32'h0);
        exp_rd = 32'h0;
        MemRead = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        run_access(1'b1, 1'b0, 3'd2, 32'h24, 32'h0, 1);
        check_eq("post_rst_lw", RD, mem[9]);

        for (int n = 0; n < 250; n++) begin
            kind = $urandom_range(0, 9);
            a = $urandom;
            if ($urandom_range(0, 1) == 0) a[1:0] = 2'b00;
            f3 = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'($urandom_range(0, 2));
            if ($urandom_range(0, 2) == 0 && f3 < 3'd2) f3 = f3 + 3'd4;
            ack_at = ($urandom_range(0, 9) == 0) ? -1 : $urandom_range(0, 3);
            case (kind)
                0:       run_access(1'b0, 1'b0, f3, a, $urandom, ack_at);
                1:       run_access(1'b1, 1'b1, f3, a, $urandom, ack_at);
                2, 3, 4, 5: run_access(1'b1, 1'b0, f3, a, $urandom, ack_at);
                default: run_access(1'b0, 1'b1, f3, a, $urandom, ack_at);
            endcase
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
